// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor and door-state encodings for the elevator call panel
package elevator_pkg;

    typedef enum logic [1:0] {
        F0 = 2'b00,
        F1 = 2'b01,
        F2 = 2'b10,
        F3 = 2'b11
    } floor_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OPEN    = 2'b01,
        CLOSING = 2'b10
    } door_state_e;

endpackage

// File: rtl/call_debounce.sv
// rtl/call_debounce.sv - hall-button synchronizer, optional debounce and rising-edge press detector
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   btn_raw   - raw asynchronous button level
//   press     - one-cycle pulse per accepted press
// Build option: CALL_PANEL_DEBOUNCE_EN adds the DB_CYCLES stable-level filter.
module call_debounce
`ifdef CALL_PANEL_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    logic [1:0] sync_q, sync_d;
    logic       level;
    logic       level_prev_q, level_prev_d;

    assign sync_d = {sync_q[0], btn_raw};

`ifdef CALL_PANEL_DEBOUNCE_EN
    localparam logic [3:0] DB_TARGET = 4'(DB_CYCLES);

    logic [3:0] db_cnt_q, db_cnt_d;

    // Counts consecutive high synchronized samples, saturating at the target;
    // a single low sample restarts the count.
    always_comb begin
        db_cnt_d = db_cnt_q;
        if (!sync_q[1]) begin
            db_cnt_d = 4'd0;
        end else if (db_cnt_q != DB_TARGET) begin
            db_cnt_d = db_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= 4'd0;
        end else begin
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = (db_cnt_q == DB_TARGET);
`else
    assign level = sync_q[1];
`endif

    assign level_prev_d = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b00;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            level_prev_q <= level_prev_d;
        end
    end

    // A held button produces exactly one pulse: only the rising edge counts.
    assign press = level & ~level_prev_q;

endmodule

// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - three-floor hall-call panel with pending calls and door dwell FSM
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   btn1..btn3          - raw hall-call buttons, floors 1..3
//   floor[1:0]          - current car floor (00 ground, 01..11 floors 1..3)
//   req1..req3          - registered call requests, masked while doors are busy
//   door_open           - registered, high while the door dwells open
//   lamp1..lamp3        - call-acknowledge lamps (pending bits)
// Build option: CALL_PANEL_DEBOUNCE_EN enables press debouncing (DB_CYCLES).
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = 8,
    parameter int DB_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       btn3,
    input  logic [1:0] floor,
    output logic       req1,
    output logic       req2,
    output logic       req3,
    output logic       door_open,
    output logic       lamp1,
    output logic       lamp2,
    output logic       lamp3
);

    localparam logic [7:0] DWELL_RELOAD = 8'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES < 2 || DWELL_CYCLES > 255) begin : g_bad_dwell
        $error("DWELL_CYCLES out of range 2..255");
    end
    if (DB_CYCLES < 1 || DB_CYCLES > 15) begin : g_bad_db
        $error("DB_CYCLES out of range 1..15");
    end

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn3, btn2, btn1};

    for (genvar g = 0; g < 3; g++) begin : g_call
        call_debounce
`ifdef CALL_PANEL_DEBOUNCE_EN
        #(
            .DB_CYCLES(DB_CYCLES)
        )
`endif
        u_call_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[g]),
            .press  (press[g])
        );
    end

    door_state_e state_q, state_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [1:0]  open_floor_q, open_floor_d;
    logic [2:0]  pend_q, pend_d;
    logic [2:0]  req_q, req_d;
    logic        door_open_q, door_open_d;

    logic [1:0]  floor_idx;
    logic [1:0]  open_idx;

    // Bit index of a floor in the pending vector (floor 1 -> bit 0).
    assign floor_idx = floor - 2'd1;
    assign open_idx  = open_floor_q - 2'd1;

    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        open_floor_d = open_floor_q;
        pend_d       = pend_q | press;

        unique case (state_q)
            IDLE: begin
                // A press arriving on the same edge as the car counts as served.
                if (floor != F0 && (pend_q[floor_idx] || press[floor_idx])) begin
                    state_d           = OPEN;
                    dwell_d           = DWELL_RELOAD;
                    open_floor_d      = floor;
                    pend_d[floor_idx] = 1'b0;
                end
            end
            OPEN: begin
                // Floor input is ignored here; only the open floor's button matters.
                if (press[open_idx]) begin
                    dwell_d          = DWELL_RELOAD;
                    pend_d[open_idx] = 1'b0;
                end else if (dwell_q == 8'd0) begin
                    state_d = CLOSING;
                end else begin
                    dwell_d = dwell_q - 8'd1;
                end
            end
            CLOSING: begin
                if (press[open_idx]) begin
                    state_d          = OPEN;
                    dwell_d          = DWELL_RELOAD;
                    pend_d[open_idx] = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d       = (state_d == IDLE) ? pend_d : 3'b000;
        door_open_d = (state_d == OPEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dwell_q      <= 8'd0;
            open_floor_q <= F0;
            pend_q       <= 3'b000;
            req_q        <= 3'b000;
            door_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            open_floor_q <= open_floor_d;
            pend_q       <= pend_d;
            req_q        <= req_d;
            door_open_q  <= door_open_d;
        end
    end

    assign req1      = req_q[0];
    assign req2      = req_q[1];
    assign req3      = req_q[2];
    assign door_open = door_open_q;
    assign lamp1     = pend_q[0];
    assign lamp2     = pend_q[1];
    assign lamp3     = pend_q[2];

endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - self-checking bench for elevator_call_panel with behavioural model
module tb_elevator_call_panel;

    localparam int DWELL = 8;
    localparam int DB    = 4;
`ifdef CALL_PANEL_DEBOUNCE_EN
    localparam int OFF = 3;
    localparam int NH  = DB;
`else
    localparam int OFF = 2;
    localparam int NH  = 1;
`endif
    // Posedges from the first high sample until req is visible.
    localparam int LAT = OFF + NH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
    logic [1:0] floor = 2'b00;
    logic       req1, req2, req3, door_open, lamp1, lamp2, lamp3;

    elevator_call_panel #(
        .DWELL_CYCLES(DWELL),
        .DB_CYCLES   (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn1     (btn1),
        .btn2     (btn2),
        .btn3     (btn3),
        .floor    (floor),
        .req1     (req1),
        .req2     (req2),
        .req3     (req3),
        .door_open(door_open),
        .lamp1    (lamp1),
        .lamp2    (lamp2),
        .lamp3    (lamp3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [2:0] pend;
        int         left;     // open cycles remaining, 0 = door not open
        bit         closing;
        int         flr;      // floor whose door is open
    } model_t;

    model_t      m;
    logic [19:0] hist [3];    // hist[b][d] = button b sampled d+1 edges ago
    logic [2:0]  pr;

    // Press lands when the last NH samples ending OFF edges ago were high
    // and the sample just before them was low.
    function automatic logic acc(input logic [19:0] h);
        for (int i = OFF - 1; i <= OFF + NH - 2; i++) begin
            if (!h[i]) return 1'b0;
        end
        return !h[OFF + NH - 1];
    endfunction

    function automatic model_t step(input model_t s, input logic [2:0] p, input logic [1:0] fl);
        model_t     n;
        logic [2:0] own;
        int         f;
        n = s;
        if (s.left > 0 || s.closing) begin
            own    = 3'b001 << (s.flr - 1);
            n.pend = s.pend | (p & ~own);
            if ((p & own) != 3'b000) begin
                n.left    = DWELL;
                n.closing = 1'b0;
            end else if (s.left > 0) begin
                n.left    = s.left - 1;
                n.closing = (n.left == 0);
            end else begin
                n.closing = 1'b0;
            end
        end else begin
            n.pend = s.pend | p;
            f = int'(fl);
            if (f != 0 && n.pend[f-1]) begin
                n.left      = DWELL;
                n.flr       = f;
                n.pend[f-1] = 1'b0;
            end
        end
        return n;
    endfunction

    always_comb begin
        pr = 3'b000;
        for (int b = 0; b < 3; b++) pr[b] = acc(hist[b]);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '{pend: 3'b000, left: 0, closing: 1'b0, flr: 1};
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
        end else begin
            m       <= step(m, pr, floor);
            hist[0] <= {hist[0][18:0], btn1};
            hist[1] <= {hist[1][18:0], btn2};
            hist[2] <= {hist[2][18:0], btn3};
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic idle;
        idle = (m.left == 0) && !m.closing;
        chk("door_open", door_open, (m.left > 0) ? 1 : 0);
        chk("lamp1", lamp1, m.pend[0]);
        chk("lamp2", lamp2, m.pend[1]);
        chk("lamp3", lamp3, m.pend[2]);
        chk("req1", req1, idle ? m.pend[0] : 0);
        chk("req2", req2, idle ? m.pend[1] : 0);
        chk("req3", req3, idle ? m.pend[2] : 0);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int w;

        // Reset state
        cyc(2);
        chk("rst_door", door_open, 0);
        chk("rst_req", {req3, req2, req1}, 0);
        chk("rst_lamp", {lamp3, lamp2, lamp1}, 0);
        rst = 1'b0;
        cyc(2);

        // Press-to-request latency at ground floor, held button counts once
        btn1 = 1'b1;
        for (int i = 1; i <= LAT + 1; i++) begin
            cyc(1);
            chk("lat_req1", req1, (i >= LAT) ? 1 : 0);
        end
        cyc(6);
        btn1 = 1'b0;
        cyc(DB + 4);
        chk("held_lamp1", lamp1, 1);
        chk("ground_no_open", door_open, 0);
        chk("ground_req1", req1, 1);

`ifdef CALL_PANEL_DEBOUNCE_EN
        // Too-short press is rejected
        btn2 = 1'b1;
        cyc(DB - 1);
        btn2 = 1'b0;
        cyc(12);
        chk("short_req2", req2, 0);
        chk("short_lamp2", lamp2, 0);
`endif

        // Service floor 1: exactly DWELL open cycles
        floor = 2'd1;
        cnt = 0;
        repeat (20) begin
            cyc(1);
            if (door_open) cnt++;
        end
        chk("dwell_len", cnt, DWELL);
        chk("served_lamp1", lamp1, 0);
        chk("served_req1", req1, 0);

        // Masking: call floor 1 while door open at floor 3
        floor = 2'd0;
        btn3 = 1'b1;
        cyc(NH + 2);
        btn3 = 1'b0;
        cyc(LAT);
        chk("pend3_lamp", lamp3, 1);
        floor = 2'd3;
        cyc(1);
        chk("open3", door_open, 1);
        btn1 = 1'b1;
        cyc(LAT);
        btn1 = 1'b0;
        chk("mask_lamp1", lamp1, 1);
        chk("mask_req1", req1, 0);
        w = 0;
        while (door_open && w < 40) begin
            cyc(1);
            w++;
        end
        chk("door_closes", (w < 40) ? 1 : 0, 1);
        chk("closing_req1", req1, 0);
        cyc(1);
        chk("idle_req1", req1, 1);
        chk("served_lamp3", lamp3, 0);

        // Reopen: press at the open floor extends the dwell
        floor = 2'd1;
        cnt = 0;
        cyc(1);
        if (door_open) cnt++;
        btn1 = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            cyc(1);
            if (door_open) cnt++;
        end
        btn1 = 1'b0;
        w = 0;
        while (door_open && w < 40) begin
            cyc(1);
            w++;
            if (door_open) cnt++;
        end
        chk("reopen_len", cnt, DWELL + LAT);
        chk("reopen_lamp1", lamp1, 0);
        floor = 2'd0;
        cyc(3);

        // Asynchronous reset mid-open with floor 2 pending
        btn2 = 1'b1;
        btn3 = 1'b1;
        cyc(LAT + 1);
        btn2 = 1'b0;
        btn3 = 1'b0;
        floor = 2'd3;
        cyc(2);
        chk("pre_rst_door", door_open, 1);
        chk("pre_rst_lamp2", lamp2, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_door", door_open, 0);
        chk("arst_req", {req3, req2, req1}, 0);
        chk("arst_lamp", {lamp3, lamp2, lamp1}, 0);
        floor = 2'd0;
        btn1 = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(LAT + 1);
        chk("held_thru_rst", lamp1, 1);
        btn1 = 1'b0;
        cyc(4);

        // Randomized traffic
        repeat (4000) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(799) == 0) rst = 1'b1;
            if ($urandom_range(5) == 0) btn1 = ~btn1;
            if ($urandom_range(5) == 0) btn2 = ~btn2;
            if ($urandom_range(5) == 0) btn3 = ~btn3;
            if ($urandom_range(9) == 0) floor = 2'($urandom_range(3));
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
